fu_div: RTL and testbench

Iterative radix-2 restoring divider functional unit for the MDU issue port. It accepts one DIV/DIVU micro-op at a time and produces quotient (LO) and remainder (HI) after a fixed latency. It drives a physical-register writeback request plus a ROB finish request into the FU output register stage, which sits directly downstream and clears on the same pipeline flush.

---
 rtl/fu_div_pkg.sv | 16 +
 rtl/div_restoring_step.sv | 29 ++
 rtl/fu_div.sv | 189 ++++++++++++++++++
 tb/tb_fu_div.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fu_div_pkg.sv
// fu_div_pkg: shared types and constants for the iterative divider unit.
//   div_state_t : IDLE / CALC / DONE sequencing states
//   DIV_ITERS   : restoring steps per operation (one per quotient bit)
//   DIV_CNT_W   : width of the step counter
package fu_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_ITERS = 32;
    localparam int DIV_CNT_W = 6;

endpackage

// File: rtl/div_restoring_step.sv
// div_restoring_step: one combinational radix-2 restoring division step.
//   r_i / r_o : partial remainder in / out (DATA_W+1 bits)
//   q_i / q_o : quotient shift register in / out (dividend bits shift out the top)
//   d_i       : divisor magnitude
module div_restoring_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   r_i,
    input  logic [DATA_W-1:0] q_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W:0]   r_o,
    output logic [DATA_W-1:0] q_o
);

    logic [2*DATA_W:0] rq_sh;
    logic [DATA_W:0]   r_sh;
    logic [DATA_W:0]   d_ext;
    logic              ge;

    assign rq_sh = {r_i, q_i} << 1;
    assign r_sh  = rq_sh[2*DATA_W:DATA_W];
    assign d_ext = {1'b0, d_i};
    assign ge    = (r_sh >= d_ext);

    assign r_o = ge ? (r_sh - d_ext) : r_sh;
    // rq_sh[0] is always zero after the shift, so OR-ing in the new bit sets Q[0].
    assign q_o = {rq_sh[DATA_W-1:1], rq_sh[0] | ge};

endmodule

// File: rtl/fu_div.sv
// fu_div: iterative radix-2 restoring DIV/DIVU functional unit.
//   clk, rst            : clock, async active-high reset
//   flush_i             : kills any in-flight op, returns to IDLE
//   in_valid_i/in_ready_o : issue handshake (ready only in IDLE)
//   in_signed_i         : 1 = DIV, 0 = DIVU
//   in_a_i / in_b_i     : dividend / divisor
//   in_prf_lo_i/in_prf_hi_i/in_rob_id_i : destination tags
//   out_valid_o         : one-cycle result strobe
//   out_lo_o / out_hi_o : quotient / remainder
//   out_prf_lo_o/out_prf_hi_o/out_rob_id_o : echoed tags
module fu_div
    import fu_div_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int PRF_IDX_W = 7,
    parameter int ROB_IDX_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 in_signed_i,
    input  logic [DATA_W-1:0]    in_a_i,
    input  logic [DATA_W-1:0]    in_b_i,
    input  logic [PRF_IDX_W-1:0] in_prf_lo_i,
    input  logic [PRF_IDX_W-1:0] in_prf_hi_i,
    input  logic [ROB_IDX_W-1:0] in_rob_id_i,
    output logic                 out_valid_o,
    output logic [DATA_W-1:0]    out_lo_o,
    output logic [DATA_W-1:0]    out_hi_o,
    output logic [PRF_IDX_W-1:0] out_prf_lo_o,
    output logic [PRF_IDX_W-1:0] out_prf_hi_o,
    output logic [ROB_IDX_W-1:0] out_rob_id_o
);

    localparam logic [DATA_W-1:0]    ONE_W    = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(DIV_ITERS - 1);

    div_state_t            state_q, state_d;
    logic [DIV_CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W:0]       r_q, r_d;
    logic [DATA_W-1:0]     q_q, q_d;
    logic [DATA_W-1:0]     div_q, div_d;
    logic                  q_neg_q, q_neg_d;
    logic                  r_neg_q, r_neg_d;
    logic [PRF_IDX_W-1:0]  prf_lo_q, prf_lo_d;
    logic [PRF_IDX_W-1:0]  prf_hi_q, prf_hi_d;
    logic [ROB_IDX_W-1:0]  rob_id_q, rob_id_d;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_W-1:0]     out_lo_q, out_lo_d;
    logic [DATA_W-1:0]     out_hi_q, out_hi_d;
    logic [PRF_IDX_W-1:0]  out_prf_lo_q, out_prf_lo_d;
    logic [PRF_IDX_W-1:0]  out_prf_hi_q, out_prf_hi_d;
    logic [ROB_IDX_W-1:0]  out_rob_id_q, out_rob_id_d;

    logic [DATA_W:0]       step_r;
    logic [DATA_W-1:0]     step_q;
    logic [DATA_W-1:0]     abs_a, abs_b;
    logic [DATA_W-1:0]     rem_mag;

    div_restoring_step #(.DATA_W(DATA_W)) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (div_q),
        .r_o (step_r),
        .q_o (step_q)
    );

    assign abs_a = (in_signed_i && in_a_i[DATA_W-1]) ? (~in_a_i + ONE_W) : in_a_i;
    assign abs_b = (in_signed_i && in_b_i[DATA_W-1]) ? (~in_b_i + ONE_W) : in_b_i;

    // Remainder magnitude is always below 2^DATA_W once the steps complete.
    assign rem_mag = r_q[DATA_W-1:0];

    // Divide-by-zero needs no special case: every trial subtract of zero
    // succeeds (Q = all ones) and R collects the dividend magnitude, which
    // r_neg re-signs back to the original dividend.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        r_d          = r_q;
        q_d          = q_q;
        div_d        = div_q;
        q_neg_d      = q_neg_q;
        r_neg_d      = r_neg_q;
        prf_lo_d     = prf_lo_q;
        prf_hi_d     = prf_hi_q;
        rob_id_d     = rob_id_q;
        out_valid_d  = 1'b0;
        out_lo_d     = out_lo_q;
        out_hi_d     = out_hi_q;
        out_prf_lo_d = out_prf_lo_q;
        out_prf_hi_d = out_prf_hi_q;
        out_rob_id_d = out_rob_id_q;

        case (state_q)
            IDLE: begin
                if (in_valid_i && !flush_i) begin
                    r_d      = '0;
                    q_d      = abs_a;
                    div_d    = abs_b;
                    q_neg_d  = in_signed_i && (in_a_i[DATA_W-1] ^ in_b_i[DATA_W-1])
                               && (in_b_i != '0);
                    r_neg_d  = in_signed_i && in_a_i[DATA_W-1];
                    prf_lo_d = in_prf_lo_i;
                    prf_hi_d = in_prf_hi_i;
                    rob_id_d = in_rob_id_i;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_d  = 1'b1;
                out_lo_d     = q_neg_q ? (~q_q + ONE_W) : q_q;
                out_hi_d     = r_neg_q ? (~rem_mag + ONE_W) : rem_mag;
                out_prf_lo_d = prf_lo_q;
                out_prf_hi_d = prf_hi_q;
                out_rob_id_d = rob_id_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The strobe itself is left unmasked; downstream clears on the same flush.
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            r_q          <= '0;
            q_q          <= '0;
            div_q        <= '0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            prf_lo_q     <= '0;
            prf_hi_q     <= '0;
            rob_id_q     <= '0;
            out_valid_q  <= 1'b0;
            out_lo_q     <= '0;
            out_hi_q     <= '0;
            out_prf_lo_q <= '0;
            out_prf_hi_q <= '0;
            out_rob_id_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            r_q          <= r_d;
            q_q          <= q_d;
            div_q        <= div_d;
            q_neg_q      <= q_neg_d;
            r_neg_q      <= r_neg_d;
            prf_lo_q     <= prf_lo_d;
            prf_hi_q     <= prf_hi_d;
            rob_id_q     <= rob_id_d;
            out_valid_q  <= out_valid_d;
            out_lo_q     <= out_lo_d;
            out_hi_q     <= out_hi_d;
            out_prf_lo_q <= out_prf_lo_d;
            out_prf_hi_q <= out_prf_hi_d;
            out_rob_id_q <= out_rob_id_d;
        end
    end

    assign in_ready_o   = (state_q == IDLE);
    assign out_valid_o  = out_valid_q;
    assign out_lo_o     = out_lo_q;
    assign out_hi_o     = out_hi_q;
    assign out_prf_lo_o = out_prf_lo_q;
    assign out_prf_hi_o = out_prf_hi_q;
    assign out_rob_id_o = out_rob_id_q;

endmodule

// File: tb/tb_fu_div.sv
// tb_fu_div: directed self-checking bench for fu_div.
module tb_fu_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic        in_signed_i = 1'b0;
    logic [31:0] in_a_i = '0;
    logic [31:0] in_b_i = '0;
    logic [6:0]  in_prf_lo_i = '0;
    logic [6:0]  in_prf_hi_i = '0;
    logic [5:0]  in_rob_id_i = '0;
    logic        out_valid_o;
    logic [31:0] out_lo_o, out_hi_o;
    logic [6:0]  out_prf_lo_o, out_prf_hi_o;
    logic [5:0]  out_rob_id_o;

    int total = 0;
    int bad   = 0;

    fu_div dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_signed_i  (in_signed_i),
        .in_a_i       (in_a_i),
        .in_b_i       (in_b_i),
        .in_prf_lo_i  (in_prf_lo_i),
        .in_prf_hi_i  (in_prf_hi_i),
        .in_rob_id_i  (in_rob_id_i),
        .out_valid_o  (out_valid_o),
        .out_lo_o     (out_lo_o),
        .out_hi_o     (out_hi_o),
        .out_prf_lo_o (out_prf_lo_o),
        .out_prf_hi_o (out_prf_hi_o),
        .out_rob_id_o (out_rob_id_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                            input logic [6:0] pl, input logic [6:0] ph, input logic [5:0] rid);
        in_signed_i = s;
        in_a_i      = a;
        in_b_i      = b;
        in_prf_lo_i = pl;
        in_prf_hi_i = ph;
        in_rob_id_i = rid;
    endtask

    // Issue one op, wait (bounded) for its strobe, check latency, results and tags.
    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [6:0] pl, input logic [6:0] ph,
                          input logic [5:0] rid, input logic [31:0] elo, input logic [31:0] ehi);
        int n;
        @(negedge clk);
        chk({tag, ".ready"}, 64'(in_ready_o), 64'd1);
        drive_op(s, a, b, pl, ph, rid);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        n = 0;
        while (!out_valid_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'd33);
        chk({tag, ".lo"}, 64'(out_lo_o), 64'(elo));
        chk({tag, ".hi"}, 64'(out_hi_o), 64'(ehi));
        chk({tag, ".tags"}, 64'({out_prf_lo_o, out_prf_hi_o, out_rob_id_o}),
            64'({pl, ph, rid}));
        @(posedge clk); #1;
        chk({tag, ".strobe_one_cycle"}, 64'(out_valid_o), 64'd0);
    endtask

    initial begin
        int first_v;
        int second_v;
        logic [31:0] lo1, hi1, lo2, hi2;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst.ready", 64'(in_ready_o), 64'd1);
        chk("rst.valid", 64'(out_valid_o), 64'd0);
        chk("rst.lo_hi", 64'({out_lo_o, out_hi_o}), 64'd0);
        chk("rst.tags", 64'({out_prf_lo_o, out_prf_hi_o, out_rob_id_o}), 64'd0);

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 7'd5, 7'd9, 6'd33, 32'd14, 32'd2);
        run_op("div_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2, 7'd1, 7'd2, 6'd3,
               32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("div_7_m2",   1'b1, 32'd7, 32'hFFFF_FFFE, 7'd127, 7'd64, 6'd63,
               32'hFFFF_FFFD, 32'd1);
        run_op("divu_by0",   1'b0, 32'h0000_1234, 32'd0, 7'd10, 7'd11, 6'd12,
               32'hFFFF_FFFF, 32'h0000_1234);
        run_op("div_min_by0", 1'b1, 32'h8000_0000, 32'd0, 7'd20, 7'd21, 6'd22,
               32'hFFFF_FFFF, 32'h8000_0000);
        run_op("div_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 7'd30, 7'd31, 6'd32,
               32'h8000_0000, 32'd0);

        // Flush while the counter reads 10
        @(negedge clk);
        drive_op(1'b0, 32'd500, 32'd3, 7'd40, 7'd41, 6'd42);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush.ready", 64'(in_ready_o), 64'd1);
        chk("flush.valid", 64'(out_valid_o), 64'd0);

        // in_valid together with flush is not accepted
        @(negedge clk);
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        chk("flush_issue.not_accepted", 64'(in_ready_o), 64'd1);

        // Stale strobe from the flushed op would show up as a short latency here
        run_op("after_flush", 1'b0, 32'd500, 32'd3, 7'd43, 7'd44, 6'd45, 32'd166, 32'd2);

        // Async reset between edges in the middle of CALC
        @(negedge clk);
        drive_op(1'b1, 32'd9, 32'd2, 7'd50, 7'd51, 6'd52);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst.ready", 64'(in_ready_o), 64'd1);
        chk("arst.valid", 64'(out_valid_o), 64'd0);
        chk("arst.lo_hi", 64'({out_lo_o, out_hi_o}), 64'd0);
        chk("arst.tags", 64'({out_prf_lo_o, out_prf_hi_o, out_rob_id_o}), 64'd0);
        #1 rst = 1'b0;

        run_op("after_arst", 1'b1, 32'd9, 32'd2, 7'd53, 7'd54, 6'd55, 32'd4, 32'd1);

        // Back-to-back with in_valid held high: accepts at t and t+34
        @(negedge clk);
        drive_op(1'b0, 32'd1000, 32'd10, 7'd60, 7'd61, 6'd1);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        drive_op(1'b1, 32'hFFFF_FF9C, 32'd7, 7'd70, 7'd71, 6'd2);
        first_v  = -1;
        second_v = -1;
        lo1 = '0; hi1 = '0; lo2 = '0; hi2 = '0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (k == 33) chk("b2b.ready_after_done", 64'(in_ready_o), 64'd1);
            if (k == 34) begin
                chk("b2b.second_accepted", 64'(in_ready_o), 64'd0);
                in_valid_i = 1'b0;
            end
            if (out_valid_o) begin
                if (first_v < 0) begin
                    first_v = k; lo1 = out_lo_o; hi1 = out_hi_o;
                end else if (second_v < 0) begin
                    second_v = k; lo2 = out_lo_o; hi2 = out_hi_o;
                end
            end
        end
        in_valid_i = 1'b0;
        chk("b2b.first_at", 64'(first_v), 64'd33);
        chk("b2b.second_at", 64'(second_v), 64'd67);
        chk("b2b.op1", 64'({lo1, hi1}), {32'd100, 32'd0});
        chk("b2b.op2", 64'({lo2, hi2}), {32'hFFFF_FFF2, 32'hFFFF_FFFE});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
